// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-read hazard scoreboard.
package reg_scoreboard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_LONG = 2'd2
    } wr_class_e;

    localparam int          NUM_GPR  = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One GPR's pending-write state: busy, long-latency flag and load countdown.
module sb_entry #(
    parameter int LOAD_LAT = 2,
    parameter int CW       = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic set_load,
    input  logic set_long,
    input  logic wb_clr,
    input  logic flush,
    output logic busy,
    output logic long
);

    logic [CW-1:0] cnt;

    // A new issue wins over both the countdown expiry and a writeback clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= 1'b0;
            long <= 1'b0;
            cnt  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            long <= 1'b0;
            cnt  <= '0;
        end else if (set_load) begin
            busy <= 1'b1;
            long <= 1'b0;
            cnt  <= CW'(LOAD_LAT - 1);
        end else if (set_long) begin
            busy <= 1'b1;
            long <= 1'b1;
            cnt  <= '0;
        end else if (wb_clr && long) begin
            busy <= 1'b0;
            long <= 1'b0;
        end else if (busy && !long) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register hazard controller: tracks load/long-op destinations and stalls dependent reads.
// Optional stall counter enabled by defining SCOREBOARD_PERF_EN.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int CW       = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic        pipe_hold,
    input  logic        flush,
    input  logic [4:0]  r1,
    input  logic [4:0]  r2,
    input  logic        r1_used,
    input  logic        r2_used,
    input  logic        wr_en,
    input  logic [4:0]  wr_reg,
    input  logic [1:0]  wr_class,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    output logic        stall,
    output logic        id_fire,
    output logic [31:0] busy_vec,
    output logic        long_busy,
    output logic [31:0] perf_stall_cnt
);

    logic [NUM_GPR-1:0] long_vec;
    logic raw1, raw2, waw, struct_haz;
    logic fire_wr, fire_load, fire_long;

    assign raw1       = r1_used && (r1 != REG_ZERO) && busy_vec[r1];
    assign raw2       = r2_used && (r2 != REG_ZERO) && busy_vec[r2];
    assign waw        = wr_en && (wr_reg != REG_ZERO) && busy_vec[wr_reg] && long_vec[wr_reg];
    assign struct_haz = wr_en && (wr_class == CLS_LONG) && long_busy;

    assign stall   = id_valid && (raw1 || raw2 || waw || struct_haz);
    assign id_fire = id_valid && !stall && !pipe_hold && !flush;

    assign fire_wr   = id_fire && wr_en && (wr_reg != REG_ZERO);
    assign fire_load = fire_wr && (wr_class == CLS_LOAD);
    assign fire_long = fire_wr && (wr_class == CLS_LONG);

    // Register 0 is hard-wired idle; entries exist only for 1..31.
    assign busy_vec[0] = 1'b0;
    assign long_vec[0] = 1'b0;

    for (genvar i = 1; i < NUM_GPR; i++) begin : g_entry
        sb_entry #(
            .LOAD_LAT (LOAD_LAT),
            .CW       (CW)
        ) u_entry (
            .clk      (clk),
            .resetn   (resetn),
            .set_load (fire_load && (wr_reg == 5'(i))),
            .set_long (fire_long && (wr_reg == 5'(i))),
            .wb_clr   (wb_en && (wb_reg == 5'(i))),
            .flush    (flush),
            .busy     (busy_vec[i]),
            .long     (long_vec[i])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            long_busy <= 1'b0;
        end else if (flush) begin
            long_busy <= 1'b0;
        end else if (fire_long) begin
            long_busy <= 1'b1;
        end else if (wb_en && long_vec[wb_reg]) begin
            long_busy <= 1'b0;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt <= '0;
        end else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, reset corner case, randomized run vs model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, pipe_hold, flush;
    logic [4:0]  r1, r2;
    logic        r1_used, r2_used;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [1:0]  wr_class;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic        stall, id_fire, long_busy;
    logic [31:0] busy_vec, perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining load-busy cycles and outstanding long op per register.
    int          m_rem  [32];
    bit          m_long [32];
    bit          m_lb;
    int          m_perf;

    typedef struct packed {
        logic       v, ph, fl;
        logic [4:0] a1;
        logic       u1;
        logic [4:0] a2;
        logic       u2;
        logic       we;
        logic [4:0] wreg;
        logic [1:0] wc;
        logic       wbe;
        logic [4:0] wbr;
        logic       es, ef, el;
    } vec_t;

    vec_t tbl [29];

    reg_scoreboard #(.LOAD_LAT(LAT), .CW(3)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .id_valid       (id_valid),
        .pipe_hold      (pipe_hold),
        .flush          (flush),
        .r1             (r1),
        .r2             (r2),
        .r1_used        (r1_used),
        .r2_used        (r2_used),
        .wr_en          (wr_en),
        .wr_reg         (wr_reg),
        .wr_class       (wr_class),
        .wb_en          (wb_en),
        .wb_reg         (wb_reg),
        .stall          (stall),
        .id_fire        (id_fire),
        .busy_vec       (busy_vec),
        .long_busy      (long_busy),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic v, ph, fl, input logic [4:0] a1, input logic u1,
                                 input logic [4:0] a2, input logic u2, input logic we,
                                 input logic [4:0] wreg, input logic [1:0] wc, input logic wbe,
                                 input logic [4:0] wbr, input logic es, ef, el);
        vec_t t;
        t = '{v:v, ph:ph, fl:fl, a1:a1, u1:u1, a2:a2, u2:u2, we:we, wreg:wreg,
              wc:wc, wbe:wbe, wbr:wbr, es:es, ef:ef, el:el};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rem[i]  = 0;
            m_long[i] = 1'b0;
        end
        m_lb   = 1'b0;
        m_perf = 0;
    endtask

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && ((m_rem[r] > 0) || m_long[r]);
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = m_busy(5'(i));
        return b;
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (r1_used && m_busy(r1)) || (r2_used && m_busy(r2)) ||
            (wr_en && m_busy(wr_reg) && m_long[wr_reg]) ||
            (wr_en && wr_class == CLS_LONG && m_lb);
        return id_valid && h;
    endfunction

    task automatic apply_stimulus(input vec_t t);
        id_valid = t.v;  pipe_hold = t.ph; flush = t.fl;
        r1 = t.a1; r1_used = t.u1; r2 = t.a2; r2_used = t.u2;
        wr_en = t.we; wr_reg = t.wreg; wr_class = t.wc;
        wb_en = t.wbe; wb_reg = t.wbr;
    endtask

    // Called just after a rising edge with inputs applied: checks at the falling edge, then advances the model.
    task automatic check_output(input string tag);
        bit s, f;
        @(negedge clk);
        s = m_stall();
        f = id_valid && !s && !pipe_hold && !flush;
        check({tag, " stall"},     {31'd0, stall},     {31'd0, s});
        check({tag, " id_fire"},   {31'd0, id_fire},   {31'd0, f});
        check({tag, " busy_vec"},  busy_vec,           m_busy_vec());
        check({tag, " long_busy"}, {31'd0, long_busy}, {31'd0, m_lb});
        @(posedge clk);
        if (s) m_perf++;
        if (flush) begin
            for (int i = 0; i < 32; i++) begin
                m_rem[i] = 0;
                m_long[i] = 1'b0;
            end
            m_lb = 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) if (m_rem[i] > 0) m_rem[i]--;
            if (wb_en && m_long[wb_reg]) begin
                m_long[wb_reg] = 1'b0;
                m_lb = 1'b0;
            end
            if (f && wr_en && wr_reg != 5'd0) begin
                if (wr_class == CLS_LOAD) begin
                    m_rem[wr_reg]  = LAT;
                    m_long[wr_reg] = 1'b0;
                end else if (wr_class == CLS_LONG) begin
                    m_rem[wr_reg]  = 0;
                    m_long[wr_reg] = 1'b1;
                    m_lb = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef SCOREBOARD_PERF_EN
        check(tag, perf_stall_cnt, 32'(m_perf));
`else
        check(tag, perf_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        //           v  ph fl a1 u1 a2 u2 we wreg wc        wbe wbr es ef el
        tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 0, 0);
        tbl[1]  = mkv(1, 0, 0, 0, 0, 0, 0, 1, 5,  CLS_LOAD, 0, 0,  0, 1, 0);
        tbl[2]  = mkv(1, 0, 0, 5, 1, 0, 0, 1, 6,  CLS_ALU,  0, 0,  1, 0, 0);
        tbl[3]  = mkv(1, 0, 0, 5, 1, 0, 0, 1, 6,  CLS_ALU,  0, 0,  1, 0, 0);
        tbl[4]  = mkv(1, 0, 0, 5, 1, 0, 0, 1, 6,  CLS_ALU,  0, 0,  0, 1, 0);
        tbl[5]  = mkv(1, 0, 0, 0, 0, 0, 0, 1, 8,  CLS_LONG, 0, 0,  0, 1, 0);
        tbl[6]  = mkv(1, 0, 0, 0, 0, 8, 1, 0, 0,  CLS_ALU,  0, 0,  1, 0, 1);
        tbl[7]  = mkv(1, 0, 0, 0, 0, 8, 1, 0, 0,  CLS_ALU,  1, 8,  1, 0, 1);
        tbl[8]  = mkv(1, 0, 0, 0, 0, 8, 1, 0, 0,  CLS_ALU,  0, 0,  0, 1, 0);
        tbl[9]  = mkv(1, 0, 0, 0, 0, 0, 0, 1, 10, CLS_LONG, 0, 0,  0, 1, 0);
        tbl[10] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 11, CLS_LONG, 0, 0,  1, 0, 1);
        tbl[11] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 11, CLS_LONG, 1, 10, 1, 0, 1);
        tbl[12] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 11, CLS_LONG, 0, 0,  0, 1, 0);
        tbl[13] = mkv(1, 0, 0, 0, 1, 0, 0, 1, 0,  CLS_LOAD, 0, 0,  0, 1, 1);
        tbl[14] = mkv(1, 0, 1, 0, 0, 0, 0, 1, 9,  CLS_LOAD, 0, 0,  0, 0, 1);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 0, 0);
        tbl[16] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 3,  CLS_LOAD, 0, 0,  0, 1, 0);
        tbl[17] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 0, 0);
        tbl[18] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 3,  CLS_LOAD, 0, 0,  0, 1, 0);
        tbl[19] = mkv(1, 0, 0, 3, 1, 0, 0, 0, 0,  CLS_ALU,  0, 0,  1, 0, 0);
        tbl[20] = mkv(1, 0, 0, 3, 1, 0, 0, 0, 0,  CLS_ALU,  0, 0,  1, 0, 0);
        tbl[21] = mkv(1, 0, 0, 3, 1, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 1, 0);
        tbl[22] = mkv(1, 1, 0, 3, 1, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 0, 0);
        tbl[23] = mkv(1, 1, 0, 0, 0, 0, 0, 1, 4,  CLS_LOAD, 0, 0,  0, 0, 0);
        tbl[24] = mkv(1, 0, 0, 4, 1, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 1, 0);
        tbl[25] = mkv(1, 0, 0, 0, 0, 0, 0, 1, 7,  CLS_LOAD, 0, 0,  0, 1, 0);
        tbl[26] = mkv(0, 0, 0, 7, 1, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 0, 0);
        tbl[27] = mkv(1, 0, 0, 0, 0, 7, 1, 0, 0,  CLS_ALU,  0, 0,  1, 0, 0);
        tbl[28] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,  CLS_ALU,  0, 0,  0, 0, 0);

        resetn = 1'b0;
        apply_stimulus(tbl[0]);
        model_reset();
        #12;
        check("reset busy_vec", busy_vec, 32'd0);
        check("reset long_busy", {31'd0, long_busy}, 32'd0);
        check("reset perf", perf_stall_cnt, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) begin
            apply_stimulus(tbl[i]);
            #3;
            check($sformatf("tbl[%0d] stall", i),     {31'd0, stall},     {31'd0, tbl[i].es});
            check($sformatf("tbl[%0d] id_fire", i),   {31'd0, id_fire},   {31'd0, tbl[i].ef});
            check($sformatf("tbl[%0d] long_busy", i), {31'd0, long_busy}, {31'd0, tbl[i].el});
            check_output($sformatf("tbl[%0d]", i));
        end
        check_perf("perf after table");

        // Long op on $9 lost to an asynchronous reset; its later writeback must be ignored.
        apply_stimulus(mkv(1, 0, 0, 0, 0, 0, 0, 1, 9, CLS_LONG, 0, 0, 0, 0, 0));
        check_output("rst long issue");
        apply_stimulus(mkv(1, 0, 0, 3, 1, 9, 1, 0, 0, CLS_ALU, 0, 0, 0, 0, 0));
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("midreset busy_vec", busy_vec, 32'd0);
        check("midreset long_busy", {31'd0, long_busy}, 32'd0);
        check("midreset stall", {31'd0, stall}, 32'd0);
        check_perf("midreset perf");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(mkv(1, 0, 0, 9, 1, 0, 0, 0, 0, CLS_ALU, 1, 9, 0, 0, 0));
        check_output("post reset wb");
        apply_stimulus(mkv(1, 0, 0, 9, 1, 0, 0, 1, 12, CLS_LONG, 0, 0, 0, 0, 0));
        check_output("post reset long");

        for (int n = 0; n < 3000; n++) begin
            vec_t t;
            t.v    = ($urandom_range(0, 9) < 8);
            t.ph   = ($urandom_range(0, 99) < 15);
            t.fl   = ($urandom_range(0, 99) < 3);
            t.a1   = 5'($urandom_range(0, 7));
            t.u1   = 1'($urandom);
            t.a2   = 5'($urandom_range(0, 7));
            t.u2   = 1'($urandom);
            t.we   = ($urandom_range(0, 9) < 7);
            t.wreg = 5'($urandom_range(0, 7));
            t.wc   = 2'($urandom_range(0, 3));
            t.wbe  = ($urandom_range(0, 3) == 0);
            t.wbr  = 5'($urandom_range(0, 7));
            t.es   = 1'b0;
            t.ef   = 1'b0;
            t.el   = 1'b0;
            apply_stimulus(t);
            check_output("rand");
        end
        check_perf("perf final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
